mem_line_master: RTL and testbench

MEM_LINE_MASTER -- requirements
Module: mem_line_master

---
 rtl/mem_line_master.sv | 191 +++++++++++++++++++
 tb/tb_mem_line_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_master.sv
// mem_line_master: single-line write-back buffer between a word-oriented
// processor port and a line-oriented slow memory.
//
// One 128-bit line is held with its tag, valid and dirty bits. Read and
// write hits are serviced in IDLE without stalling. A miss stalls the
// processor, writes the old line back if it is dirty, fetches the new
// line, and then lets the held request hit.
//
// Optional feature: define LINE_HIT_COUNT_EN to add a saturating 16-bit
// hit counter on output hit_count.
module mem_line_master (
   input  logic          clk,
   input  logic          rst,
   input  logic          proc_read,
   input  logic          proc_write,
   input  logic [29:0]   proc_addr,
   input  logic [31:0]   proc_wdata,
   output logic [31:0]   proc_rdata,
   output logic          proc_stall,
   output logic          mem_read,
   output logic          mem_write,
   output logic [27:0]   mem_addr,
   output logic [127:0]  mem_wdata,
   input  logic [127:0]  mem_rdata,
   input  logic          mem_ready
`ifdef LINE_HIT_COUNT_EN
   ,
   output logic [15:0]   hit_count
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;

   logic [127:0]   line_q;
   logic [27:0]    tag_q;
   logic           valid_q;
   logic           dirty_q;
   // Line address captured at the miss, so the memory side never sees a
   // combinational path from the processor inputs.
   logic [27:0]    fetch_addr_q;

   logic           req;
   logic           is_write;
   logic [27:0]    req_line;
   logic [1:0]     req_word;
   logic           in_idle;
   logic           hit;
   logic           idle_hit;
   logic           idle_miss;

   // Request decode; a combined read+write is handled as a write.
   always_comb begin
      req       = proc_read | proc_write;
      is_write  = proc_write;
      req_line  = proc_addr[29:2];
      req_word  = proc_addr[1:0];
      in_idle   = (state_q == IDLE);
      hit       = valid_q && (tag_q == req_line) && req;
      idle_hit  = in_idle && hit;
      idle_miss = in_idle && req && !hit;
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch
      // is inferred when a case arm does not mention a signal.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (idle_miss) begin
               state_d = (valid_q && dirty_q) ? WRITEBACK : FETCH;
            end
         end
         WRITEBACK: begin
            if (mem_ready) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (mem_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Processor-side outputs: read data on an IDLE hit, stall otherwise.
   always_comb begin
      proc_rdata = '0;
      proc_stall = !in_idle || idle_miss;
      if (idle_hit) begin
         proc_rdata = line_q[{req_word, 5'd0} +: 32];
      end
   end

   // Memory-side outputs, decoded only from state and registers.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         WRITEBACK: begin
            mem_write = 1'b1;
            mem_addr  = tag_q;
            mem_wdata = line_q;
         end
         FETCH: begin
            mem_read  = 1'b1;
            mem_addr  = fetch_addr_q;
         end
         default: ;
      endcase
   end

   // Line bookkeeping: tag, valid, dirty and the captured fetch address.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q        <= '0;
         valid_q      <= 1'b0;
         dirty_q      <= 1'b0;
         fetch_addr_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (idle_hit && is_write) begin
                  dirty_q <= 1'b1;
               end else if (idle_miss) begin
                  fetch_addr_q <= req_line;
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  dirty_q <= 1'b0;
               end
            end
            FETCH: begin
               if (mem_ready) begin
                  tag_q   <= fetch_addr_q;
                  valid_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Line data: word update on a write hit, full refill at fetch completion.
   always_ff @(posedge clk) begin
      // NOTE: the data storage has no reset; valid_q marks it meaningless
      // until the first fetch, so clearing it would only cost reset fan-out.
      if (!rst) begin
         if (idle_hit && is_write) begin
            line_q[{req_word, 5'd0} +: 32] <= proc_wdata;
         end else if ((state_q == FETCH) && mem_ready) begin
            line_q <= mem_rdata;
         end
      end
   end

`ifdef LINE_HIT_COUNT_EN
   // Saturating count of non-stalled hit cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count <= '0;
      end else if (idle_hit && (hit_count != 16'hFFFF)) begin
         hit_count <= hit_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_line_master.sv
// Randomised self-checking bench for mem_line_master. A one-line cache
// model plus a sparse backing memory predict every memory transaction and
// every read word; the bench itself plays the slow memory with random
// latencies. Define LINE_HIT_COUNT_EN to also check hit_count.
module tb_mem_line_master;

   logic          clk = 1'b0;
   logic          rst;
   logic          proc_read;
   logic          proc_write;
   logic [29:0]   proc_addr;
   logic [31:0]   proc_wdata;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          mem_read;
   logic          mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata;
   logic          mem_ready;
`ifdef LINE_HIT_COUNT_EN
   logic [15:0]   hit_count;
`endif

   mem_line_master dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef LINE_HIT_COUNT_EN
      ,
      .hit_count  (hit_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: one cached line and the memory behind it.
   logic          m_valid;
   logic          m_dirty;
   logic [27:0]   m_tag;
   logic [127:0]  m_line;
   int            m_hits;
   logic [127:0]  backing [logic [27:0]];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic get_line(input logic [27:0] a, output logic [127:0] l);
      if (!backing.exists(a)) backing[a] = {$urandom, $urandom, $urandom, $urandom};
      l = backing[a];
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_dirty = 1'b0;
      m_tag   = '0;
      m_hits  = 0;
   endtask

   // One complete processor request, from presentation to the idle cycle after it.
   task automatic do_req(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [31:0] wdata);
      logic [27:0]  la;
      logic [127:0] l;
      int           w;
      int           lat;
      bit           hit;
      la  = addr[29:2];
      w   = int'(addr[1:0]);
      hit = m_valid && (m_tag == la);
      @(negedge clk);
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = addr;
      proc_wdata = wdata;
      #1;
      if (!hit) begin
         check("miss_stall", proc_stall, 1);
         check("miss_no_rd", mem_read, 0);
         check("miss_no_wr", mem_write, 0);
         if (m_valid && m_dirty) begin
            lat = $urandom_range(1, 4);
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               mem_ready = (i == lat - 1);
               #1;
               check("wb_write", mem_write, 1);
               check("wb_no_rd", mem_read, 0);
               check("wb_addr", mem_addr, m_tag);
               check("wb_data", mem_wdata, m_line);
               check("wb_stall", proc_stall, 1);
            end
            backing[m_tag] = m_line;
            m_dirty = 1'b0;
         end
         get_line(la, l);
         lat = $urandom_range(1, 4);
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            mem_ready = (i == lat - 1);
            mem_rdata = mem_ready ? l : {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("fetch_read", mem_read, 1);
            check("fetch_no_wr", mem_write, 0);
            check("fetch_addr", mem_addr, la);
            check("fetch_stall", proc_stall, 1);
         end
         m_line  = l;
         m_tag   = la;
         m_valid = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         #1;
      end
      check("hit_stall", proc_stall, 0);
      check("hit_no_rd", mem_read, 0);
      check("hit_no_wr", mem_write, 0);
      if (rd && !wr) check("rdata", proc_rdata, m_line[w*32 +: 32]);
      if (wr) begin
         m_line[w*32 +: 32] = wdata;
         m_dirty = 1'b1;
      end
      if (m_hits < 65535) m_hits++;
      @(negedge clk);
      proc_read  = 1'b0;
      proc_write = 1'b0;
      #1;
      check("idle_stall", proc_stall, 0);
`ifdef LINE_HIT_COUNT_EN
      check("hit_count", hit_count, m_hits);
`endif
   endtask

   // Abandon a fetch with reset; a late mem_ready must be ignored.
   task automatic reset_mid_fetch();
      logic [27:0] la;
      la = m_tag + 28'd1;
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = {la, 2'b00};
      #1;
      check("rmf_miss_stall", proc_stall, 1);
      @(negedge clk);
      #1;
      check("rmf_in_fetch", mem_read, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      proc_read = 1'b0;
      #1;
      model_reset();
      check("rmf_rd", mem_read, 0);
      check("rmf_wr", mem_write, 0);
      check("rmf_addr", mem_addr, 0);
      check("rmf_stall", proc_stall, 0);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("late_ready_rd", mem_read, 0);
      check("late_ready_wr", mem_write, 0);
      check("late_ready_stall", proc_stall, 0);
`ifdef LINE_HIT_COUNT_EN
      check("rmf_hit_count", hit_count, 0);
`endif
   endtask

   initial begin
      logic [29:0] addr;
      int          op;
      rst        = 1'b1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_stall", proc_stall, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rdata", proc_rdata, 0);
`ifdef LINE_HIT_COUNT_EN
      check("rst_hit_count", hit_count, 0);
`endif

      // Cold read, write hit, read-back, read+write as write, dirty eviction.
      backing[28'h4] = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
      do_req(1'b1, 1'b0, 30'h10, 32'h0);
      do_req(1'b0, 1'b1, 30'h11, 32'hDEADBEEF);
      do_req(1'b1, 1'b0, 30'h11, 32'h0);
      do_req(1'b1, 1'b1, 30'h12, 32'h5);
      do_req(1'b1, 1'b0, 30'h12, 32'h0);
      do_req(1'b1, 1'b0, 30'h20, 32'h0);
      check("evicted_word1", backing[28'h4][63:32], 32'hDEADBEEF);
      check("evicted_word2", backing[28'h4][95:64], 32'h5);

      reset_mid_fetch();
      // After reset the line is invalid: this read must miss again.
      do_req(1'b1, 1'b0, 30'h20, 32'h0);
      do_req(1'b1, 1'b0, 30'h21, 32'h0);
      do_req(1'b1, 1'b0, 30'h22, 32'h0);

      // Random mix over a few lines so hits, clean and dirty misses all occur.
      for (int i = 0; i < 200; i++) begin
         addr = 30'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
         op   = $urandom_range(0, 3);
         do_req(op != 1, op != 0, addr, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
